// File: rtl/hwt_trigger_seq.sv
// ---------------------------------------------------------------------------
// hwt_trigger_seq
//
// Sequential trigger stage for the HWT payload cell. It watches the observed
// nibble bus for the four-nibble pattern SEQ0,SEQ1,SEQ2,SEQ3 and counts
// complete occurrences in a saturating counter. Once the count reaches
// THRESH, the stage arms and drives the payload activation inputs A..D into
// the active combination. The payload computes D & (A&B | C), so trig_d low
// keeps the payload inactive.
//
// Build option:
//   HWT_TRIGGER_EN  defined   -> trigger outputs operate normally
//                   undefined -> trig_a..trig_d and armed are tied to 0;
//                                the FSM, match_cnt and clear still operate
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   din        in   observed bus nibble (4 bits)
//   din_valid  in   din is sampled only when high
//   clear      in   synchronous disarm; clears FSM, counter, armed, phase
//   trig_a     out  payload A: armed & phase
//   trig_b     out  payload B: armed
//   trig_c     out  payload C: one-cycle complete-match pulse
//   trig_d     out  payload D: armed
//   armed      out  trigger armed status
//   match_cnt  out  complete matches seen, saturating (CNT_W bits)
// ---------------------------------------------------------------------------
module hwt_trigger_seq #(
    parameter logic [3:0] SEQ0   = 4'hA,
    parameter logic [3:0] SEQ1   = 4'h5,
    parameter logic [3:0] SEQ2   = 4'hC,
    parameter logic [3:0] SEQ3   = 4'h3,
    parameter int         THRESH = 3,
    parameter int         CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             trig_a,
    output logic             trig_b,
    output logic             trig_c,
    output logic             trig_d,
    output logic             armed,
    output logic [CNT_W-1:0] match_cnt
);

`ifdef HWT_TRIGGER_EN
    localparam logic TRIG_EN = 1'b1;
`else
    localparam logic TRIG_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GOT1 = 2'd1,
        GOT2 = 2'd2,
        GOT3 = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [3:0]       expected;
    logic             match_hit;
    logic [CNT_W-1:0] cnt_inc;
    logic             armed_q;
    logic             phase_q;
    logic             pulse_q;

    // State register. clear wins over anything the FSM would do this beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Only valid beats move the FSM. A mismatching SEQ0
    // re-enters GOT1 so a restarted pattern is not lost; completed matches
    // go back to IDLE (overlaps are deliberately not tracked).
    always_comb begin
        next_state = state;
        match_hit  = 1'b0;
        expected   = SEQ0;
        unique case (state)
            IDLE: expected = SEQ0;
            GOT1: expected = SEQ1;
            GOT2: expected = SEQ2;
            GOT3: expected = SEQ3;
        endcase
        if (din_valid) begin
            if (din == expected) begin
                unique case (state)
                    IDLE: next_state = GOT1;
                    GOT1: next_state = GOT2;
                    GOT2: next_state = GOT3;
                    GOT3: begin
                        next_state = IDLE;
                        match_hit  = 1'b1;
                    end
                endcase
            end else if (din == SEQ0) begin
                next_state = GOT1;
            end else begin
                next_state = IDLE;
            end
        end
    end

    // Saturating increment; the arming decision looks at this post-increment
    // value so the THRESH-th match arms on the same edge it is counted.
    always_comb begin
        cnt_inc = (match_cnt == CNT_MAX) ? match_cnt : match_cnt + CNT_W'(1);
    end

    // Counter, armed flag, phase toggle and the one-cycle match pulse.
    // phase only moves while already armed, so it starts at 0 on the arming
    // edge and toggles on each valid beat afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt <= '0;
            armed_q   <= 1'b0;
            phase_q   <= 1'b0;
            pulse_q   <= 1'b0;
        end else if (clear) begin
            match_cnt <= '0;
            armed_q   <= 1'b0;
            phase_q   <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            pulse_q <= match_hit;
            if (din_valid && armed_q) begin
                phase_q <= ~phase_q;
            end
            if (match_hit) begin
                match_cnt <= cnt_inc;
                if (cnt_inc >= THRESH_V) begin
                    armed_q <= 1'b1;
                end
            end
        end
    end

    // Output mapping; in the non-active build every activation input is
    // forced low so the payload can never fire.
    always_comb begin
        armed  = TRIG_EN & armed_q;
        trig_a = TRIG_EN & armed_q & phase_q;
        trig_b = TRIG_EN & armed_q;
        trig_c = TRIG_EN & pulse_q;
        trig_d = TRIG_EN & armed_q;
    end

endmodule

// File: tb/tb_hwt_trigger_seq.sv
// ---------------------------------------------------------------------------
// tb_hwt_trigger_seq
//
// Self-checking bench for hwt_trigger_seq. A behavioural reference model
// predicts the registered outputs for every beat; the prediction is queued
// when the beat is driven and compared after the clock edge that captures it.
// Works for both builds (HWT_TRIGGER_EN defined or not).
// ---------------------------------------------------------------------------
module tb_hwt_trigger_seq;

`ifdef HWT_TRIGGER_EN
    localparam bit TRIG_EN = 1'b1;
`else
    localparam bit TRIG_EN = 1'b0;
`endif

    localparam int THRESH  = 3;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic             clk;
    logic             rst;
    logic [3:0]       din;
    logic             din_valid;
    logic             clear;
    logic             trig_a;
    logic             trig_b;
    logic             trig_c;
    logic             trig_d;
    logic             armed;
    logic [CNT_W-1:0] match_cnt;

    typedef struct {
        bit a;
        bit b;
        bit c;
        bit d;
        bit arm;
        int cnt;
    } expect_t;

    expect_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_state;
    int m_cnt;
    bit m_armed;
    bit m_phase;
    bit m_pulse;
    logic [3:0] seq_tab [4];

    hwt_trigger_seq #(
        .SEQ0(4'hA), .SEQ1(4'h5), .SEQ2(4'hC), .SEQ3(4'h3),
        .THRESH(THRESH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .clear(clear), .trig_a(trig_a), .trig_b(trig_b), .trig_c(trig_c),
        .trig_d(trig_d), .armed(armed), .match_cnt(match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_armed = 1'b0;
        m_phase = 1'b0;
        m_pulse = 1'b0;
    endtask

    // One beat of the behavioural model, written from the pattern rules.
    task automatic model_step(input logic [3:0] nib, input bit valid, input bit clr);
        bit hit;
        hit = 1'b0;
        if (clr) begin
            model_reset();
        end else begin
            if (valid) begin
                if (nib == seq_tab[m_state]) begin
                    if (m_state == 3) begin
                        hit     = 1'b1;
                        m_state = 0;
                    end else begin
                        m_state = m_state + 1;
                    end
                end else begin
                    m_state = (nib == seq_tab[0]) ? 1 : 0;
                end
                if (m_armed) m_phase = ~m_phase;
            end
            if (hit) begin
                if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
                if (m_cnt >= THRESH) m_armed = 1'b1;
            end
            m_pulse = hit;
        end
    endtask

    function automatic expect_t model_outputs();
        expect_t e;
        e.a   = TRIG_EN & m_armed & m_phase;
        e.b   = TRIG_EN & m_armed;
        e.c   = TRIG_EN & m_pulse;
        e.d   = TRIG_EN & m_armed;
        e.arm = TRIG_EN & m_armed;
        e.cnt = m_cnt;
        return e;
    endfunction

    task automatic compare_all(input string tag, input expect_t e);
        checkOutput({tag, "_a"},   int'(trig_a), int'(e.a));
        checkOutput({tag, "_b"},   int'(trig_b), int'(e.b));
        checkOutput({tag, "_c"},   int'(trig_c), int'(e.c));
        checkOutput({tag, "_d"},   int'(trig_d), int'(e.d));
        checkOutput({tag, "_arm"}, int'(armed),  int'(e.arm));
        checkOutput({tag, "_cnt"}, int'(match_cnt), e.cnt);
    endtask

    // Drive one beat at the falling edge, queue the prediction, then compare
    // the DUT just after the rising edge that captures the beat.
    task automatic applyStimulus(input logic [3:0] nib, input bit valid, input bit clr);
        expect_t e;
        @(negedge clk);
        din       = nib;
        din_valid = valid;
        clear     = clr;
        model_step(nib, valid, clr);
        exp_q.push_back(model_outputs());
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checkOutput("queue_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            compare_all("beat", e);
        end
        din_valid = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic send_seq();
        applyStimulus(4'hA, 1'b1, 1'b0);
        applyStimulus(4'h5, 1'b1, 1'b0);
        applyStimulus(4'hC, 1'b1, 1'b0);
        applyStimulus(4'h3, 1'b1, 1'b0);
    endtask

    task automatic idle_beats(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 1'b0, 1'b0);
        end
    endtask

    initial begin
        seq_tab[0] = 4'hA;
        seq_tab[1] = 4'h5;
        seq_tab[2] = 4'hC;
        seq_tab[3] = 4'h3;
        model_reset();
        rst       = 1'b1;
        din       = 4'h0;
        din_valid = 1'b0;
        clear     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_cnt",   int'(match_cnt), 0);
        checkOutput("rst_armed", int'(armed), 0);
        checkOutput("rst_trig",  int'({trig_a, trig_b, trig_c, trig_d}), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single pattern: counted, pulse on C, not yet armed
        send_seq();
        checkOutput("one_cnt",   int'(match_cnt), 1);
        checkOutput("one_trigc", int'(trig_c), int'(TRIG_EN));
        checkOutput("one_armed", int'(armed), 0);
        idle_beats(1);
        checkOutput("one_trigc_fall", int'(trig_c), 0);

        // Two more patterns reach the threshold, then phase toggling
        send_seq();
        send_seq();
        checkOutput("arm_cnt",   int'(match_cnt), 3);
        checkOutput("arm_armed", int'(armed), int'(TRIG_EN));
        checkOutput("arm_trigd", int'(trig_d), int'(TRIG_EN));
        checkOutput("arm_triga", int'(trig_a), 0);
        applyStimulus(4'h0, 1'b1, 1'b0);
        checkOutput("phase1_triga", int'(trig_a), int'(TRIG_EN));
        applyStimulus(4'h0, 1'b1, 1'b0);
        applyStimulus(4'h0, 1'b1, 1'b0);

        // Re-entry on mismatching SEQ0: exactly one match
        applyStimulus(4'h0, 1'b0, 1'b1);
        applyStimulus(4'hA, 1'b1, 1'b0);
        applyStimulus(4'h5, 1'b1, 1'b0);
        send_seq();
        checkOutput("reentry_cnt", int'(match_cnt), 1);

        // Broken pattern: no match
        applyStimulus(4'h0, 1'b0, 1'b1);
        applyStimulus(4'hA, 1'b1, 1'b0);
        applyStimulus(4'h5, 1'b1, 1'b0);
        applyStimulus(4'h7, 1'b1, 1'b0);
        applyStimulus(4'hC, 1'b1, 1'b0);
        applyStimulus(4'h3, 1'b1, 1'b0);
        checkOutput("broken_cnt", int'(match_cnt), 0);

        // clear coincident with the final SEQ3 of an armed design
        send_seq();
        send_seq();
        send_seq();
        applyStimulus(4'hA, 1'b1, 1'b0);
        applyStimulus(4'h5, 1'b1, 1'b0);
        applyStimulus(4'hC, 1'b1, 1'b0);
        applyStimulus(4'h3, 1'b1, 1'b1);
        checkOutput("clr_armed", int'(armed), 0);
        checkOutput("clr_cnt",   int'(match_cnt), 0);
        checkOutput("clr_trigc", int'(trig_c), 0);

        // Gaps of invalid beats inside the pattern
        applyStimulus(4'hA, 1'b1, 1'b0);
        idle_beats(5);
        applyStimulus(4'h5, 1'b1, 1'b0);
        idle_beats(5);
        applyStimulus(4'hC, 1'b1, 1'b0);
        idle_beats(5);
        applyStimulus(4'h3, 1'b1, 1'b0);
        checkOutput("gap_cnt", int'(match_cnt), 1);

        // Asynchronous reset while armed and sitting in GOT2
        send_seq();
        send_seq();
        applyStimulus(4'hA, 1'b1, 1'b0);
        applyStimulus(4'h5, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_cnt",   int'(match_cnt), 0);
        checkOutput("arst_armed", int'(armed), 0);
        checkOutput("arst_trig",  int'({trig_a, trig_b, trig_c, trig_d}), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        // C,3 alone must not complete a match after reset
        applyStimulus(4'hC, 1'b1, 1'b0);
        applyStimulus(4'h3, 1'b1, 1'b0);
        checkOutput("arst_restart_cnt", int'(match_cnt), 0);
        send_seq();

        // Saturation: pulses continue, count holds at max
        for (int i = 0; i < 16; i++) send_seq();
        checkOutput("sat_cnt",   int'(match_cnt), CNT_MAX);
        checkOutput("sat_trigc", int'(trig_c), int'(TRIG_EN));
        idle_beats(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
